// File: rtl/gate_checker.sv
// gate_checker: walks all 2^N_IN input vectors of a gate and checks its output.
// Optional first-failure capture is built when GATE_CHECKER_FAIL_CAPTURE_EN is defined.
module gate_checker #(
    parameter int                 N_IN   = 2,
    parameter logic [2**N_IN-1:0] TRUTH  = 4'b1110,
    parameter int                 SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_a,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
);

    localparam int VW = N_IN + 1;
    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [VW-1:0] LAST = VW'(2**N_IN - 1);
    localparam logic [WW-1:0] WLAST = WW'(SETTLE - 1);
    localparam logic [VW-1:0] ONE = VW'(1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [VW-1:0] vec;
    logic [WW-1:0] wcnt;
    logic          accept;
    logic          settled;
    logic          is_last;
    logic          mism;

    assign accept  = start && (state == IDLE || state == DONE);
    assign settled = (wcnt == WLAST);
    assign is_last = (vec == LAST);
    assign mism    = (state == SAMPLE) && (dut_y != TRUTH[vec[N_IN-1:0]]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = DRIVE;
            DRIVE:      if (settled) state_nxt = SAMPLE;
            SAMPLE:     state_nxt = is_last ? DONE : DRIVE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        dut_a = '0;
        unique case (state)
            DRIVE, SAMPLE: begin
                busy  = 1'b1;
                dut_a = vec[N_IN-1:0];
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign pass = done && (err_count == '0);

    // vec is one bit wider than dut_a so the last vector compares cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            wcnt      <= '0;
            err_count <= '0;
        end else if (accept) begin
            vec       <= '0;
            wcnt      <= '0;
            err_count <= '0;
        end else if (state == DRIVE) begin
            if (!settled) wcnt <= wcnt + WW'(1);
        end else if (state == SAMPLE) begin
            if (mism) err_count <= err_count + ONE;
            if (!is_last) begin
                vec  <= vec + ONE;
                wcnt <= '0;
            end
        end
    end

`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else if (accept) begin
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else if (mism && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= vec[N_IN-1:0];
        end
    end
`else
    assign fail_valid = 1'b0;
    assign fail_vec   = '0;
`endif

endmodule

// File: tb/tb_gate_checker.sv
// tb_gate_checker: randomized gate tables checked against a truth-table model.
// Fail-capture expectations follow GATE_CHECKER_FAIL_CAPTURE_EN.
module tb_gate_checker;

    localparam int N_IN = 2;
    localparam int SETTLE = 2;
    localparam logic [3:0] TRUTH = 4'b1110;
    localparam int NV = 4;
    localparam int RUN = NV * (SETTLE + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dut_a;
    logic       dut_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic       fail_valid;
    logic [1:0] fail_vec;
    logic [3:0] gate_tbl = 4'b1110;

    int checks = 0;
    int failures = 0;

    gate_checker #(
        .N_IN(N_IN),
        .TRUTH(TRUTH),
        .SETTLE(SETTLE)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dut_a(dut_a),
        .dut_y(dut_y),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .fail_valid(fail_valid),
        .fail_vec(fail_vec)
    );

    always #5 clk = ~clk;

    // behavioural gate under test: a plain lookup table
    always_comb dut_y = gate_tbl[dut_a];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_errs(input logic [3:0] tbl);
        int n = 0;
        for (int i = 0; i < NV; i++)
            if (tbl[i] != TRUTH[i]) n++;
        return n;
    endfunction

    function automatic int exp_fvec(input logic [3:0] tbl);
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
        for (int i = 0; i < NV; i++)
            if (tbl[i] != TRUTH[i]) return i;
`endif
        return 0;
    endfunction

    function automatic int exp_fvalid(input logic [3:0] tbl);
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
        return (exp_errs(tbl) != 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic run_check(input logic [3:0] tbl, input bit poke);
        gate_tbl = tbl;
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < RUN; c++) begin
            @(negedge clk);
            start = poke && (c == 4);
            chk("busy", 32'(busy), 1);
            chk("done_lo", 32'(done), 0);
            chk("pass_lo", 32'(pass), 0);
            chk("dut_a", 32'(dut_a), 32'(c / (SETTLE + 1)));
            if (c == 0) begin
                chk("err_clr", 32'(err_count), 0);
                chk("fv_clr", 32'(fail_valid), 0);
            end
        end
        @(negedge clk);
        chk("done", 32'(done), 1);
        chk("busy_lo", 32'(busy), 0);
        chk("err", 32'(err_count), 32'(exp_errs(tbl)));
        chk("pass", 32'(pass), (exp_errs(tbl) == 0) ? 1 : 0);
        chk("fail_valid", 32'(fail_valid), 32'(exp_fvalid(tbl)));
        chk("fail_vec", 32'(fail_vec), 32'(exp_fvec(tbl)));
        chk("dut_a_done", 32'(dut_a), 0);
        @(negedge clk);
        chk("done_hold", 32'(done), 1);
        chk("err_hold", 32'(err_count), 32'(exp_errs(tbl)));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_err"}, 32'(err_count), 0);
        chk({tag, "_fv"}, 32'(fail_valid), 0);
        chk({tag, "_fvec"}, 32'(fail_vec), 0);
        chk({tag, "_a"}, 32'(dut_a), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int hits;
        int first_hit;
        int second_hit;
        logic [3:0] t;

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("idle");

        run_check(4'b1110, 1'b0);
        run_check(4'b0000, 1'b0);
        run_check(4'b1000, 1'b0);
        run_check(4'b1110, 1'b1);
        run_check(4'b0000, 1'b0);
        run_check(4'b1110, 1'b0);

        // asynchronous reset in the middle of a run
        gate_tbl = 4'b0000;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_check(4'b1110, 1'b0);

        // start held high: one cycle of done between back-to-back runs
        gate_tbl = 4'b1110;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        hits = 0;
        first_hit = -1;
        second_hit = -1;
        for (int c = 0; c < 2 * RUN + 3; c++) begin
            @(negedge clk);
            if (done) begin
                hits++;
                if (first_hit < 0) first_hit = c;
                else if (second_hit < 0) second_hit = c;
            end
        end
        start = 1'b0;
        chk("held_hits", 32'(hits), 2);
        chk("held_first", 32'(first_hit), RUN);
        chk("held_second", 32'(second_hit), 2 * RUN + 1);
        repeat (2 * RUN) @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            t = 4'($urandom_range(0, 15));
            run_check(t, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
